// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package adder_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefStages = 2;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bus for pipelined_adder.
// Defining ADDER_SUB_EN adds the per-beat subtract select.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One chunk of the carry-chained adder: registered chunk sum, carry out and valid bit.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = chunk_width(DefWidth, DefStages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic             valid_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o
);

  logic             valid_d, valid_q;
  logic             c_d, c_q;
  logic [CHUNK-1:0] sum_d, sum_q;

  always_comb begin
    valid_d      = valid_i;
    {c_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      sum_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign c_o     = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chained adder split into STAGES chunks with operand skew and sum deskew registers.
// Defining ADDER_SUB_EN enables a + ~b + 1 subtraction per beat.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef ADDER_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.c_in;
`endif

  // The whole pipe freezes while the output beat is held back.
  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]         op_a, op_b, sum;
    logic                     cin, vin, cout, vout;
    logic [(k+1)*CHUNK-1:0]   full_sum;

    if (k == 0) begin : g_src
      assign op_a     = bus.a[CHUNK-1:0];
      assign op_b     = b_eff[CHUNK-1:0];
      assign cin      = c_eff;
      assign vin      = bus.in_valid;
      assign full_sum = sum;
    end else begin : g_src
      logic [k*CHUNK-1:0] lo_d, lo_q;

      assign op_a = g_stage[k-1].g_skew.hi_a_q[CHUNK-1:0];
      assign op_b = g_stage[k-1].g_skew.hi_b_q[CHUNK-1:0];
      assign cin  = g_stage[k-1].cout;
      assign vin  = g_stage[k-1].vout;

      always_comb lo_d = g_stage[k-1].full_sum;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     lo_q <= '0;
        else if (en) lo_q <= lo_d;
      end

      assign full_sum = {sum, lo_q};
    end

    // Upper operand chunks not yet consumed travel alongside the beat.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned HiW = WIDTH - (k + 1) * CHUNK;
      logic [HiW-1:0] hi_a_d, hi_a_q, hi_b_d, hi_b_q;

      if (k == 0) begin : g_in
        always_comb begin
          hi_a_d = bus.a[WIDTH-1:CHUNK];
          hi_b_d = b_eff[WIDTH-1:CHUNK];
        end
      end else begin : g_in
        always_comb begin
          hi_a_d = g_stage[k-1].g_skew.hi_a_q[HiW+CHUNK-1:CHUNK];
          hi_b_d = g_stage[k-1].g_skew.hi_b_q[HiW+CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hi_a_q <= '0;
          hi_b_q <= '0;
        end else if (en) begin
          hi_a_q <= hi_a_d;
          hi_b_q <= hi_b_d;
        end
      end
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .valid_i(vin),
      .a_i    (op_a),
      .b_i    (op_b),
      .c_i    (cin),
      .valid_o(vout),
      .sum_o  (sum),
      .c_o    (cout)
    );

    if (k == STAGES - 1) begin : g_out
      logic msb_x_d, msb_x_q;

      always_comb msb_x_d = op_a[CHUNK-1] ^ op_b[CHUNK-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     msb_x_q <= 1'b0;
        else if (en) msb_x_q <= msb_x_d;
      end

      assign bus.out_valid = vout;
      assign bus.s         = full_sum;
      assign bus.c_out     = cout;
      // Carry into the MSB is a^b^s at that bit.
      assign bus.ovf       = cout ^ msb_x_q ^ full_sum[(k+1)*CHUNK-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2).
module tb_pipelined_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [9:0] exp;  // {c_out, s, ovf}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] held;
  logic       held_v = 1'b0;
  bit         rnd_done;
  vec_t       rv;

  pipelined_adder_if #(.WIDTH(8)) bus ();

  pipelined_adder #(
    .WIDTH (8),
    .STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[12] = '{
    '{8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 8'h10, 1'b0}},
    '{8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 8'h01, 1'b0}},
    '{8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 8'h80, 1'b1}},
    '{8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 8'h00, 1'b1}},
    '{8'h00, 8'h00, 1'b0, 1'b0, {1'b0, 8'h00, 1'b0}},
    '{8'hFF, 8'hFF, 1'b1, 1'b0, {1'b1, 8'hFF, 1'b0}},
    '{8'h80, 8'hFF, 1'b0, 1'b0, {1'b1, 8'h7F, 1'b1}},
    '{8'h55, 8'hAA, 1'b1, 1'b0, {1'b1, 8'h00, 1'b0}},
    '{8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 8'h46, 1'b0}},
    '{8'h0F, 8'hF0, 1'b1, 1'b0, {1'b1, 8'h00, 1'b0}},
    '{8'h7F, 8'h7F, 1'b1, 1'b0, {1'b0, 8'hFF, 1'b1}},
    '{8'h08, 8'h08, 1'b0, 1'b0, {1'b0, 8'h10, 1'b0}}
  };

`ifdef ADDER_SUB_EN
  vec_t sub_vecs[2] = '{
    '{8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 8'hFE, 1'b0}},
    '{8'h07, 8'h05, 1'b1, 1'b1, {1'b1, 8'h02, 1'b0}}
  };
`endif

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] f;
    f = {1'b0, a} + {1'b0, b} + {8'b0, ci};
    return {f[8], f[7:0], (a[7] == b[7]) && (f[7] != a[7])};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input vec_t v);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.c_in     = v.ci;
`ifdef ADDER_SUB_EN
    bus.sub      = v.sb;
`endif
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(v.exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= 64) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck low for %0d cycles", n);
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  // Monitor: pops on every output transfer and checks holding during stalls.
  always @(negedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else begin
      if (held_v) check("stall_hold", {5'b0, bus.out_valid, bus.c_out, bus.s, bus.ovf},
                        {5'b0, 1'b1, held});
      if (bus.out_valid && !bus.out_ready) begin
        check("in_ready_stall", 16'(bus.in_ready), 16'd0);
        held   <= {bus.c_out, bus.s, bus.ovf};
        held_v <= 1'b1;
      end else begin
        held_v <= 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", {bus.c_out, bus.s, bus.ovf});
        end else begin
          check("result", 16'({bus.c_out, bus.s, bus.ovf}), 16'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif

    #3;
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_s", 16'(bus.s), 16'd0);
    check("rst_c_out", 16'(bus.c_out), 16'd0);
    check("rst_ovf", 16'(bus.ovf), 16'd0);
    check("rst_in_ready", 16'(bus.in_ready), 16'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: first beat right after reset, result exactly two cycles later.
    send(vecs[0]);
    @(negedge clk);
    check("lat_cycle1", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    check("lat_cycle2", 16'(bus.out_valid), 16'd1);
    @(posedge clk);
    #1;

    for (int i = 1; i < 12; i++) send(vecs[i]);
`ifdef ADDER_SUB_EN
    for (int i = 0; i < 2; i++) send(sub_vecs[i]);
`endif
    drain("drain_directed");

    // Four back-to-back beats with the sink stalling for three cycles.
    fork
      begin
        for (int i = 8; i < 12; i++) send(vecs[i]);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Random operands with bubbles and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          rv.a   = 8'($urandom);
          rv.b   = 8'($urandom);
          rv.ci  = 1'($urandom);
          rv.sb  = 1'b0;
          rv.exp = model(rv.a, rv.b, rv.ci);
          send(rv);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_random");

    // Reset with two beats in flight and the output stalled.
    bus.out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    check("midrst_s", 16'(bus.s), 16'd0);
    check("midrst_c_out", 16'(bus.c_out), 16'd0);
    check("midrst_ovf", 16'(bus.ovf), 16'd0);
    check("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 16'(bus.out_valid), 16'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[3]);
    drain("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
